// File: rtl/ranger_pkg.sv
// ranger_pkg : shared FSM states and timing helpers for multi_ultrasonic_ranger
// rev 1.0
`default_nettype none

package ranger_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_ECHO = 3'd2,
      MEASURE   = 3'd3,
      HOLDOFF   = 3'd4
   } state_e;

   function automatic int unsigned slot_cyc(input int unsigned clk_hz, input int unsigned slot_ms);
      return (clk_hz / 1000) * slot_ms;
   endfunction

   // Multiply before dividing so slow test clocks still give non-zero counts
   function automatic int unsigned us_to_cyc(input int unsigned clk_hz, input int unsigned us);
      longint unsigned prod;
      prod = 64'(clk_hz) * 64'(us);
      return 32'(prod / 64'd1000000);
   endfunction

   function automatic int unsigned trig_cyc(input int unsigned clk_hz, input int unsigned trig_us);
      return us_to_cyc(clk_hz, trig_us);
   endfunction

   function automatic int unsigned cyc_per_cm(input int unsigned clk_hz);
      return us_to_cyc(clk_hz, 58);
   endfunction

   function automatic int unsigned to_cyc(input int unsigned clk_hz, input int unsigned timeout_us);
      return us_to_cyc(clk_hz, timeout_us);
   endfunction

   // Bits needed to hold the values 0 .. n-1
   function automatic int unsigned cnt_w(input longint unsigned n);
      return (n <= 1) ? 1 : 32'($clog2(n));
   endfunction

endpackage

`default_nettype wire

// File: rtl/echo_width_meter.sv
// echo_width_meter : waits for an echo rising edge and converts its width to cm
// rev 1.0
`default_nettype none

module echo_width_meter
   import ranger_pkg::*;
#(
   parameter int unsigned DIST_W     = 8,
   parameter int unsigned TO_CYC     = 1250000,
   parameter int unsigned CYC_PER_CM = 2900
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              echo,
   output logic              rise,
   output logic              done,
   output logic              timed_out,
   output logic [DIST_W-1:0] cm
);

   localparam int unsigned        CNT_W   = cnt_w(TO_CYC);
   localparam int unsigned        PS_W    = cnt_w(CYC_PER_CM);
   localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TO_CYC - 1);
   localparam logic [PS_W-1:0]    PS_LAST = PS_W'(CYC_PER_CM - 1);
   localparam logic [DIST_W-1:0]  CM_MAX  = '1;

   state_e             phase_q, phase_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PS_W-1:0]    ps_q, ps_d;
   logic [DIST_W-1:0]  cm_q, cm_d;
   logic               echo_prev_q;
   logic               echo_edge;

   assign echo_edge = echo & ~echo_prev_q;

   always_comb begin
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      ps_d      = ps_q;
      cm_d      = cm_q;
      rise      = 1'b0;
      done      = 1'b0;
      timed_out = 1'b0;
      cm        = cm_q;
      if (start) begin
         phase_d = WAIT_ECHO;
         cnt_d   = '0;
      end else begin
         case (phase_q)
            WAIT_ECHO: begin
               // The rising cycle itself is the first counted cycle of the width
               if (echo_edge) begin
                  rise    = 1'b1;
                  phase_d = MEASURE;
                  cnt_d   = CNT_W'(1);
                  ps_d    = PS_W'(1);
                  cm_d    = '0;
               end else if (cnt_q == TO_LAST) begin
                  done      = 1'b1;
                  timed_out = 1'b1;
                  cm        = CM_MAX;
                  phase_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            MEASURE: begin
               if (!echo) begin
                  done    = 1'b1;
                  phase_d = IDLE;
               end else if (cnt_q == TO_LAST) begin
                  done      = 1'b1;
                  timed_out = 1'b1;
                  cm        = CM_MAX;
                  phase_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (ps_q == PS_LAST) begin
                     ps_d = '0;
                     if (cm_q != CM_MAX) cm_d = cm_q + DIST_W'(1);
                  end else begin
                     ps_d = ps_q + PS_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q     <= IDLE;
         cnt_q       <= '0;
         ps_q        <= '0;
         cm_q        <= '0;
         echo_prev_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         ps_q        <= ps_d;
         cm_q        <= cm_d;
         echo_prev_q <= echo;
      end
   end

endmodule

`default_nettype wire

// File: rtl/multi_ultrasonic_ranger.sv
// multi_ultrasonic_ranger : round-robin HC-SR04 scheduler with per-channel averaging
// rev 1.0
`default_nettype none

module multi_ultrasonic_ranger
   import ranger_pkg::*;
#(
   parameter int unsigned N_CH        = 2,
   parameter int unsigned CLK_FREQ_HZ = 50000000,
   parameter int unsigned SLOT_MS     = 60,
   parameter int unsigned TRIG_US     = 10,
   parameter int unsigned TIMEOUT_US  = 25000,
   parameter int unsigned DIST_W      = 8,
   parameter int unsigned AVG_LOG2    = 2,
   parameter int unsigned NEAR_CM     = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [N_CH-1:0]          echo,
   output logic [N_CH-1:0]          trig,
   output logic [N_CH*DIST_W-1:0]   distance,
   output logic [N_CH-1:0]          valid,
   output logic [N_CH-1:0]          timeout,
   output logic [N_CH-1:0]          near,
   output logic [DIST_W-1:0]        min_distance,
   output logic                     busy
);

   localparam int unsigned SLOT_C    = slot_cyc(CLK_FREQ_HZ, SLOT_MS);
   localparam int unsigned TRIG_C    = trig_cyc(CLK_FREQ_HZ, TRIG_US);
   localparam int unsigned TO_C      = to_cyc(CLK_FREQ_HZ, TIMEOUT_US);
   localparam int unsigned CPC       = cyc_per_cm(CLK_FREQ_HZ);
   localparam int unsigned SLOT_W    = cnt_w(SLOT_C);
   localparam int unsigned CH_W      = cnt_w(N_CH);
   localparam int unsigned WIN       = 1 << AVG_LOG2;
   localparam int unsigned SUM_W     = DIST_W + AVG_LOG2;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_C - 1);
   localparam logic [SLOT_W-1:0] TRIG_LAST = SLOT_W'(TRIG_C - 1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);

   logic [N_CH-1:0]   echo_meta_q, echo_sync_q;
   state_e            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [N_CH-1:0]   trig_q, trig_d;
   logic [N_CH-1:0]   valid_q, valid_d;
   logic [N_CH-1:0]   timeout_q, timeout_d;
   logic [N_CH-1:0]   near_q, near_d;
   logic [DIST_W-1:0] min_q, min_d;
   logic [DIST_W-1:0] dist_q [N_CH];
   logic [DIST_W-1:0] dist_d [N_CH];
   logic [DIST_W-1:0] win_q  [N_CH][WIN];
   logic [DIST_W-1:0] win_d  [N_CH][WIN];
   logic [SUM_W-1:0]  win_sum;
   logic              start, commit;
   logic              m_rise, m_done, m_timed_out;
   logic [DIST_W-1:0] m_cm;
   logic              echo_sel;

   assign echo_sel = echo_sync_q[ch_q];

   echo_width_meter #(
      .DIST_W     (DIST_W),
      .TO_CYC     (TO_C),
      .CYC_PER_CM (CPC)
   ) u_meter (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .echo      (echo_sel),
      .rise      (m_rise),
      .done      (m_done),
      .timed_out (m_timed_out),
      .cm        (m_cm)
   );

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      slot_d    = (slot_q == SLOT_LAST) ? slot_q : slot_q + SLOT_W'(1);
      start     = 1'b0;
      commit    = 1'b0;
      case (state_q)
         IDLE: if (enable) begin
            state_d = TRIG;
            slot_d  = '0;
         end
         TRIG: if (slot_q == TRIG_LAST) begin
            state_d = WAIT_ECHO;
            start   = 1'b1;
         end
         WAIT_ECHO: begin
            if (m_done) begin
               state_d = HOLDOFF;
               commit  = 1'b1;
            end else if (m_rise) begin
               state_d = MEASURE;
            end
         end
         MEASURE: if (m_done) begin
            state_d = HOLDOFF;
            commit  = 1'b1;
         end
         HOLDOFF: if (slot_q == SLOT_LAST) begin
            ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
            if (enable) begin
               state_d = TRIG;
               slot_d  = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      trig_d = '0;
      if (state_d == TRIG) trig_d[ch_d] = 1'b1;

      // Result lands on the edge into HOLDOFF, so valid is high in its first cycle
      win_d     = win_q;
      dist_d    = dist_q;
      valid_d   = '0;
      timeout_d = timeout_q;
      win_sum   = '0;
      if (commit) begin
         for (int i = 0; i < int'(WIN) - 1; i++) win_d[ch_q][i] = win_q[ch_q][i+1];
         win_d[ch_q][WIN-1] = m_cm;
         for (int i = 0; i < int'(WIN); i++) win_sum = win_sum + SUM_W'(win_d[ch_q][i]);
         dist_d[ch_q]    = DIST_W'(win_sum >> AVG_LOG2);
         timeout_d[ch_q] = m_timed_out;
         valid_d[ch_q]   = 1'b1;
      end

      min_d = '1;
      for (int k = 0; k < int'(N_CH); k++) begin
         if (dist_d[k] < min_d) min_d = dist_d[k];
         near_d[k] = (32'(dist_d[k]) < NEAR_CM);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_meta_q <= '0;
         echo_sync_q <= '0;
         state_q     <= IDLE;
         ch_q        <= '0;
         slot_q      <= '0;
         trig_q      <= '0;
         valid_q     <= '0;
         timeout_q   <= '0;
         near_q      <= '0;
         min_q       <= '1;
         for (int k = 0; k < int'(N_CH); k++) begin
            dist_q[k] <= '1;
            for (int i = 0; i < int'(WIN); i++) win_q[k][i] <= '1;
         end
      end else begin
         echo_meta_q <= echo;
         echo_sync_q <= echo_meta_q;
         state_q     <= state_d;
         ch_q        <= ch_d;
         slot_q      <= slot_d;
         trig_q      <= trig_d;
         valid_q     <= valid_d;
         timeout_q   <= timeout_d;
         near_q      <= near_d;
         min_q       <= min_d;
         dist_q      <= dist_d;
         win_q       <= win_d;
      end
   end

   generate
      for (genvar k = 0; k < int'(N_CH); k++) begin : g_dist
         assign distance[k*DIST_W +: DIST_W] = dist_q[k];
      end
   endgenerate

   assign trig         = trig_q;
   assign valid        = valid_q;
   assign timeout      = timeout_q;
   assign near         = near_q;
   assign min_distance = min_q;
   assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire
